// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle RISC-V control unit.
// The optional LUI/AUIPC support is enabled by defining CTRL_UTYPE_EN.
package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    JALR     = 4'd11,
`ifdef CTRL_UTYPE_EN
    UTYPE    = 4'd12,
`endif
    TRAP     = 4'd13
  } state_e;

  // Opcodes (instr[6:0])
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Immediate generator selects
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  // ALU operation codes
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  // Operation class handed to the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

  // Datapath operand/result selects; SRCA_ZERO lets LUI pass the immediate through the adder
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;

endpackage

// File: rtl/alu_decoder.sv
// Maps operation class, funct3 and funct7b5 to the ALU operation code.
module alu_decoder import ctrl_pkg::*; (
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [3:0] alu_control
);

  // Purely combinational operation select; subtract only exists for R-type
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      default: begin
        case (funct3)
          3'b000:  alu_control = (alu_op == ALUOP_RTYPE && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_control = ALU_SLL;
          3'b010:  alu_control = ALU_SLT;
          3'b011:  alu_control = ALU_SLTU;
          3'b100:  alu_control = ALU_XOR;
          3'b101:  alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_control = ALU_OR;
          default: alu_control = ALU_AND;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V control FSM. Define CTRL_UTYPE_EN to add LUI/AUIPC support.
module multicycle_ctrl import ctrl_pkg::*; (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       ir_write,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       mem_read,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_control,
  output logic [2:0] imm_src,
  output logic       illegal
);

  state_e     state_q, state_d;
  logic       illegal_q, illegal_d;
  logic [1:0] alu_op;
  logic [3:0] alu_ctl;

  alu_decoder u_alu_dec (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .alu_control (alu_ctl)
  );

  // Next state; memory states wait on mem_ready, TRAP only leaves via reset
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:    if (mem_ready) state_d = DECODE;
      DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = MEMADR;
          OP_RTYPE:          state_d = EXECR;
          OP_ITYPE:          state_d = EXECI;
          OP_BRANCH:         state_d = BRANCH;
          OP_JAL:            state_d = JAL;
          OP_JALR:           state_d = JALR;
`ifdef CTRL_UTYPE_EN
          OP_LUI, OP_AUIPC:  state_d = UTYPE;
`endif
          default:           state_d = TRAP;
        endcase
      end
      MEMADR:   state_d = (op == OP_STORE) ? MEMWRITE : MEMREAD;
      MEMREAD:  if (mem_ready) state_d = MEMWB;
      MEMWB:    state_d = FETCH;
      MEMWRITE: if (mem_ready) state_d = FETCH;
      EXECR:    state_d = ALUWB;
      EXECI:    state_d = ALUWB;
      ALUWB:    state_d = FETCH;
      BRANCH:   state_d = (funct3 == 3'b000 || funct3 == 3'b001) ? FETCH : TRAP;
      JAL:      state_d = ALUWB;
      JALR:     state_d = JAL;
`ifdef CTRL_UTYPE_EN
      UTYPE:    state_d = ALUWB;
`endif
      TRAP:     state_d = TRAP;
      default:  state_d = TRAP;
    endcase
    illegal_d = illegal_q | (state_d == TRAP);
  end

  // State and sticky illegal flag; reset abandons any access in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // ALU operation class per state
  always_comb begin
    case (state_q)
      EXECR:   alu_op = ALUOP_RTYPE;
      EXECI:   alu_op = ALUOP_ITYPE;
      BRANCH:  alu_op = ALUOP_SUB;
      default: alu_op = ALUOP_ADD;
    endcase
  end

  // Moore output decode, forced idle while reset is asserted so a pending store drops at once
  always_comb begin
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    adr_src     = 1'b0;
    mem_write   = 1'b0;
    mem_read    = 1'b0;
    reg_write   = 1'b0;
    result_src  = RES_ALUOUT;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_RS2;
    alu_control = ALU_ADD;
    imm_src     = IMM_I;
    if (!reset) begin
      alu_control = alu_ctl;
      case (state_q)
        FETCH: begin
          mem_read  = 1'b1;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
          alu_src_b = SRCB_FOUR;
        end
        DECODE: begin
          alu_src_a = SRCA_OLDPC;
          alu_src_b = SRCB_IMM;
          imm_src   = IMM_B;
        end
        MEMADR: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
          imm_src   = (op == OP_STORE) ? IMM_S : IMM_I;
        end
        MEMREAD: begin
          adr_src  = 1'b1;
          mem_read = 1'b1;
        end
        MEMWB: begin
          result_src = RES_DATA;
          reg_write  = 1'b1;
        end
        MEMWRITE: begin
          adr_src   = 1'b1;
          mem_write = 1'b1;
        end
        EXECR: alu_src_a = SRCA_RS1;
        EXECI: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
        end
        ALUWB: reg_write = 1'b1;
        BRANCH: begin
          alu_src_a = SRCA_RS1;
          pc_write  = (funct3 == 3'b000 && zero) || (funct3 == 3'b001 && !zero);
        end
        JAL: begin
          pc_write  = 1'b1;
          alu_src_a = SRCA_OLDPC;
          alu_src_b = SRCB_FOUR;
        end
        JALR: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
        end
`ifdef CTRL_UTYPE_EN
        UTYPE: begin
          alu_src_a = (op == OP_LUI) ? SRCA_ZERO : SRCA_OLDPC;
          alu_src_b = SRCB_IMM;
          imm_src   = IMM_U;
        end
`endif
        default: ;
      endcase
    end
  end

  assign illegal = illegal_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl; LUI expectations follow CTRL_UTYPE_EN.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, zero, mem_ready;
  logic       ir_write, pc_write, adr_src, mem_write, mem_read, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [3:0] alu_control;
  logic [2:0] imm_src;
  logic [19:0] obs;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .ir_write(ir_write), .pc_write(pc_write),
    .adr_src(adr_src), .mem_write(mem_write), .mem_read(mem_read), .reg_write(reg_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_control(alu_control), .imm_src(imm_src), .illegal(illegal)
  );

  assign obs = {ir_write, pc_write, adr_src, mem_write, mem_read, reg_write,
                result_src, alu_src_a, alu_src_b, alu_control, imm_src, illegal};

  task automatic check(input string tag, input logic [19:0] got, input logic [19:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %05h expected %05h", tag, got, exp);
    end
  endtask

  // {ir,pc,adr,mw,mr,rw,result_src,src_a,src_b,alu_control,imm_src,illegal}
  function automatic logic [19:0] ov(input logic ir, input logic pc, input logic adr,
      input logic mw, input logic mr, input logic rw, input logic [1:0] rs,
      input logic [1:0] sa, input logic [1:0] sb, input logic [3:0] ac,
      input logic [2:0] is, input logic il);
    return {ir, pc, adr, mw, mr, rw, rs, sa, sb, ac, is, il};
  endfunction

  function automatic logic [19:0] v_fetch(input logic rdy);
    return ov(rdy, rdy, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b10, 4'h0, 3'b000, 1'b0);
  endfunction
  function automatic logic [19:0] v_decode();
    return ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 4'h0, 3'b010, 1'b0);
  endfunction
  function automatic logic [19:0] v_exec(input logic [1:0] sb, input logic [3:0] ac);
    return ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, sb, ac, 3'b000, 1'b0);
  endfunction
  function automatic logic [19:0] v_aluwb();
    return ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 4'h0, 3'b000, 1'b0);
  endfunction
  function automatic logic [19:0] v_memadr(input logic [2:0] is);
    return ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 4'h0, is, 1'b0);
  endfunction
  function automatic logic [19:0] v_memread();
    return ov(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 4'h0, 3'b000, 1'b0);
  endfunction
  function automatic logic [19:0] v_memwb();
    return ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 4'h0, 3'b000, 1'b0);
  endfunction
  function automatic logic [19:0] v_memwrite();
    return ov(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 4'h0, 3'b000, 1'b0);
  endfunction
  function automatic logic [19:0] v_branch(input logic pc);
    return ov(1'b0, pc, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 4'h1, 3'b000, 1'b0);
  endfunction
  function automatic logic [19:0] v_jal();
    return ov(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 4'h0, 3'b000, 1'b0);
  endfunction
  function automatic logic [19:0] v_jalr();
    return ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 4'h0, 3'b000, 1'b0);
  endfunction
  function automatic logic [19:0] v_trap();
    return ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 4'h0, 3'b000, 1'b1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // From FETCH: load an instruction, check FETCH and DECODE, leave DUT one edge past DECODE
  task automatic enter(input string tag, input logic [6:0] o, input logic [2:0] f3, input logic f7);
    op = o; funct3 = f3; funct7b5 = f7; mem_ready = 1'b1;
    #1 check({tag, "_fetch"}, obs, v_fetch(1'b1));
    tick();
    check({tag, "_decode"}, obs, v_decode());
    tick();
  endtask

  task automatic run_alu(input string tag, input logic [6:0] o, input logic [2:0] f3,
                         input logic f7, input logic [1:0] sb, input logic [3:0] ac);
    enter(tag, o, f3, f7);
    check({tag, "_exec"}, obs, v_exec(sb, ac));
    tick();
    check({tag, "_aluwb"}, obs, v_aluwb());
    tick();
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1 check({tag, "_in_reset"}, obs, 20'h0);
    tick();
    mem_ready = 1'b0;
    reset = 1'b0;
    #1 check({tag, "_fetch_after"}, obs, v_fetch(1'b0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; op = 7'h0; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b0;
    #1 check("reset_idle", obs, 20'h0);
    tick();
    check("reset_clocked", obs, 20'h0);
    reset = 1'b0;
    #1 check("fetch_wait", obs, v_fetch(1'b0));
    tick();
    check("fetch_wait_hold", obs, v_fetch(1'b0));

    // ALU class decode
    run_alu("add",   7'b0110011, 3'b000, 1'b0, 2'b00, 4'b0000);
    run_alu("sub",   7'b0110011, 3'b000, 1'b1, 2'b00, 4'b0001);
    run_alu("sra",   7'b0110011, 3'b101, 1'b1, 2'b00, 4'b1000);
    run_alu("srl",   7'b0110011, 3'b101, 1'b0, 2'b00, 4'b0111);
    run_alu("sltu",  7'b0110011, 3'b011, 1'b0, 2'b00, 4'b1001);
    run_alu("srai",  7'b0010011, 3'b101, 1'b1, 2'b01, 4'b1000);
    run_alu("addi7", 7'b0010011, 3'b000, 1'b1, 2'b01, 4'b0000);
    run_alu("andi",  7'b0010011, 3'b111, 1'b0, 2'b01, 4'b0010);

    // lw with three wait cycles in MEMREAD
    enter("lw", 7'b0000011, 3'b010, 1'b0);
    check("lw_memadr", obs, v_memadr(3'b000));
    mem_ready = 1'b0;
    tick();
    check("lw_memread_c1", obs, v_memread());
    tick();
    check("lw_memread_c2", obs, v_memread());
    tick();
    check("lw_memread_c3", obs, v_memread());
    tick();
    mem_ready = 1'b1;
    #1 check("lw_memread_c4", obs, v_memread());
    tick();
    check("lw_memwb", obs, v_memwb());
    tick();

    // beq / bne, pc_write follows zero within the cycle
    enter("beq", 7'b1100011, 3'b000, 1'b0);
    zero = 1'b1;
    #1 check("beq_taken", obs, v_branch(1'b1));
    zero = 1'b0;
    #1 check("beq_not_taken", obs, v_branch(1'b0));
    tick();
    enter("bne", 7'b1100011, 3'b001, 1'b0);
    #1 check("bne_taken", obs, v_branch(1'b1));
    zero = 1'b1;
    #1 check("bne_not_taken", obs, v_branch(1'b0));
    tick();
    zero = 1'b0;

    // jal and jalr
    enter("jal", 7'b1101111, 3'b000, 1'b0);
    check("jal_state", obs, v_jal());
    tick();
    check("jal_aluwb", obs, v_aluwb());
    tick();
    enter("jalr", 7'b1100111, 3'b000, 1'b0);
    check("jalr_state", obs, v_jalr());
    tick();
    check("jalr_jal", obs, v_jal());
    tick();
    check("jalr_aluwb", obs, v_aluwb());
    tick();

    // sw: stalled store aborted by asynchronous reset
    enter("sw", 7'b0100011, 3'b010, 1'b0);
    check("sw_memadr", obs, v_memadr(3'b001));
    mem_ready = 1'b0;
    tick();
    check("sw_memwrite", obs, v_memwrite());
    tick();
    check("sw_memwrite_hold", obs, v_memwrite());
    #1 do_reset("sw_abort");

    // unsupported branch funct3 traps
    tick();
    enter("blt", 7'b1100011, 3'b100, 1'b0);
    zero = 1'b1;
    #1 check("blt_branch", obs, v_branch(1'b0));
    tick();
    check("blt_trap", obs, v_trap());
    zero = 1'b0;
    do_reset("blt");

    // op = 0 traps and holds
    tick();
    enter("op0", 7'b0000000, 3'b000, 1'b0);
    check("op0_trap", obs, v_trap());
    for (int i = 0; i < 10; i++) begin
      mem_ready = i[0];
      tick();
      check("op0_trap_hold", obs, v_trap());
    end
    do_reset("op0");

    // lui x5,0x12345 (0x123452B7)
    tick();
    enter("lui", 7'b0110111, 3'b010, 1'b0);
`ifdef CTRL_UTYPE_EN
    check("lui_utype", obs, ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b11, 2'b01,
                               4'h0, 3'b011, 1'b0));
    tick();
    check("lui_aluwb", obs, v_aluwb());
    tick();
    #1 check("lui_back_fetch", obs, v_fetch(1'b1));
`else
    check("lui_trap", obs, v_trap());
    do_reset("lui");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have one clock and one reset; reset SHALL be asynchronous and active-high.
REQ-002 Ports SHALL be, as name  direction  width  meaning:
  clk  in  1  rising-edge clock
  reset  in  1  async active-high reset
  op  in  7  instr[6:0] from instruction register
  funct3  in  3  instr[14:12]
  funct7b5  in  1  instr[30]
  zero  in  1  ALU result equals zero
  mem_ready  in  1  memory completes current access this cycle
  ir_write  out  1  load instruction register
  pc_write  out  1  update PC
  adr_src  out  1  0 = PC, 1 = ALU result register as memory address
  mem_write  out  1  store request
  mem_read  out  1  load or fetch request
  reg_write  out  1  register file write enable
  result_src  out  2  00 ALUOut, 01 data, 10 ALU result
  alu_src_a  out  2  00 PC, 01 OldPC, 10 rs1
  alu_src_b  out  2  00 rs2, 01 imm, 10 constant 4
  alu_control  out  4  ALU operation code
  imm_src  out  3  000 I, 001 S, 010 B, 011 U, 100 J (immediate generator select)
  illegal  out  1  sticky unsupported-instruction flag

Function
REQ-003 States SHALL be: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR, UTYPE, TRAP.
REQ-004 FETCH: adr_src=0, mem_read=1; hold until mem_ready=1; in that cycle ir_write=1, pc_write=1, alu PC+4 (src_a=00, src_b=10, add); then go to DECODE.
REQ-005 DECODE: alu OldPC+imm with imm_src=010 (branch target precompute); next state by op: 0000011/0100011 MEMADR, 0110011 EXECR, 0010011 EXECI, 1100011 BRANCH, 1101111 JAL, 1100111 JALR, 0110111/0010111 UTYPE, other TRAP.
REQ-006 MEMADR: rs1+imm, imm_src=000 for load, 001 for store; next MEMREAD (load) or MEMWRITE (store).
REQ-007 MEMREAD: adr_src=1, mem_read=1, hold until mem_ready, then MEMWB; MEMWB: result_src=01, reg_write=1, then FETCH.
REQ-008 MEMWRITE: adr_src=1, mem_write=1 held until mem_ready=1, then FETCH.
REQ-009 EXECR/EXECI: rs1 op rs2/imm (imm_src=000), alu_control from funct3/funct7b5; then ALUWB (result_src=00, reg_write=1), then FETCH.
REQ-010 alu_control codes: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sll, 0111 srl, 1000 sra, 1001 sltu; sub only for R-type funct7b5=1; sra when funct3=101 and funct7b5=1 (both types).
REQ-011 BRANCH: rs1-rs2 (sub), pc_write=zero for funct3=000, ~zero for 001, result_src=00; other funct3 go TRAP; then FETCH.
REQ-012 JAL: pc_write=1 from ALUOut, OldPC+4 computed; then ALUWB. JALR: rs1+imm (imm_src=000), then JAL-style writeback with PC from ALU result.
REQ-013 UTYPE: imm_src=011; LUI writes imm, AUIPC writes OldPC+imm, via ALUWB.
REQ-014 TRAP: illegal=1, all enables 0, state held until reset.
REQ-015 Outputs not listed for a state SHALL be 0; outputs are Moore except BRANCH pc_write.

Reset
REQ-016 On reset: state=FETCH, illegal=0, all enables 0, selects 00, imm_src=000, alu_control=0000; reset mid-access aborts it without any write.

Configuration
REQ-017 With CTRL_UTYPE_EN defined, LUI/AUIPC SHALL be supported via UTYPE; without it, UTYPE state SHALL be absent and those opcodes go to TRAP.

Structure
REQ-018 Package ctrl_pkg SHALL hold the state enum, opcode constants, imm_src encodings, alu_control encodings.
REQ-019 Sub-module alu_decoder SHALL map op-class/funct3/funct7b5 to alu_control combinationally.

Verification
REQ-020 add x3,x1,x2 (0x002081B3), mem_ready=1: FETCH->DECODE->EXECR->ALUWB->FETCH; alu_control=0000, reg_write=1 only in ALUWB.
REQ-021 lw with mem_ready low 3 cycles in MEMREAD: state stays MEMREAD 4 cycles, mem_read=1 throughout, reg_write only in MEMWB.
REQ-022 beq with zero=1: pc_write=1 in BRANCH; with zero=0: pc_write=0; imm_src=010 in DECODE.
REQ-023 op=0000000: TRAP, illegal=1, held 10 cycles; reset clears to FETCH, illegal=0.
REQ-024 lui x5,0x12345 with macro: imm_src=011 in UTYPE, reg_write in ALUWB; without macro: TRAP.
REQ-025 reset asserted in MEMWRITE: mem_write drops immediately (async), state FETCH.
